p_core_clint: RTL and testbench
===============================

P_CORE_CLINT -- requirements
Module: p_core_clint

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0200_0000, meaning the base of the 64 KiB register window.
REQ-002 SHALL have parameter DATA_W, default 64, meaning the AXI data width (32 or 64 only).
REQ-003 SHALL have parameters req_t and resp_t, defaults rs_m_axi_req_t and rs_m_axi_resp_t, meaning the typed AXI4 request/response structs.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port arst_ni, input, 1, reset (asynchronous, active-low).
REQ-006 SHALL have port req_i, input, req_t, AXI4 slave request from the system interconnect.
REQ-007 SHALL have port resp_o, output, resp_t, AXI4 slave response.
REQ-008 SHALL have port rtc_tick_i, input, 1, synchronous one-cycle mtime increment enable.
REQ-009 SHALL have port time_irq_o, output, 1, timer interrupt to the p_core subsystem time_irq_i.
REQ-010 SHALL have port ipi_o, output, 1, software interrupt to the p_core subsystem ipi_i.

Function
REQ-011 Register map (offset from BASE_ADDR): MSIP 0x0000 (bit0 only, others read 0); MTIMECMP_LO 0x4000; MTIMECMP_HI 0x4004; MTIME_LO 0xBFF8; MTIME_HI 0xBFFC; all other offsets read 0 and ignore writes, both with OKAY response.
REQ-012 Registers SHALL be 32-bit words; with DATA_W=64 the word is selected by addr[2] and occupies lane addr[2]; with DATA_W=32 it occupies lane 0.
REQ-013 Writes SHALL honour wstrb per byte; bytes with strobe 0 are unchanged.
REQ-014 Controller SHALL handle one transaction at a time with FSM states IDLE, WDATA, WDRAIN, BRESP, RDATA.
REQ-015 IDLE: aw_ready=1 and ar_ready=0 when aw_valid=1; otherwise ar_ready=1; AW has priority on a simultaneous AW/AR.
REQ-016 AW handshake with len==0 -> WDATA; with len!=0 -> WDRAIN (error path).
REQ-017 WDATA: w_ready=1; on the W handshake apply the write and go to BRESP with resp OKAY.
REQ-018 WDRAIN: w_ready=1; discard beats; on the beat with w.last=1 go to BRESP with resp SLVERR.
REQ-019 BRESP: b_valid=1, b.id=latched AW id; hold until b_ready, then IDLE.
REQ-020 AR handshake -> RDATA with beat counter = ar.len; r.data captured from register values at the AR handshake.
REQ-021 RDATA: r_valid=1, r.id=latched id, r.last=1 when counter==0, r.resp OKAY if len==0 else SLVERR with data 0; on each r_ready decrement the counter, and leave to IDLE after the last beat.
REQ-022 Each response SHALL be held stable while valid and not ready.
REQ-023 mtime is 64-bit; it SHALL increment by 1 on rtc_tick_i and wrap from all-ones to 0.
REQ-024 A bus write to MTIME_LO/HI in the same cycle as rtc_tick_i: the written bytes take the written value, the unwritten bytes take the incremented value.
REQ-025 time_irq_o SHALL be registered: asserted the cycle after (mtime >= mtimecmp), unsigned 64-bit compare.
REQ-026 ipi_o SHALL equal MSIP bit0 directly from the register.
REQ-027 Burst type, size, cache, prot and atop fields SHALL be ignored.

Reset
REQ-028 On arst_ni low, asynchronously: FSM=IDLE, all valids/readies 0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, MSIP=0, time_irq_o=0, ipi_o=0.
REQ-029 Reset mid-transaction SHALL abandon the transaction without producing a response.
REQ-030 The first AR/AW SHALL be accepted no earlier than the first cycle after arst_ni deasserts.

Verification
REQ-031 Write 1 to MSIP (single beat) -> B OKAY with the matching id; ipi_o=1 the cycle after the W handshake; write 0 -> ipi_o=0.
REQ-032 mtimecmp=5, then 5 rtc ticks from reset -> time_irq_o rises 1 cycle after mtime reaches 5; write mtimecmp_hi=1 -> time_irq_o falls.
REQ-033 AW len=3 -> 4 W beats accepted, then one B SLVERR; registers unchanged.
REQ-034 AR len=2 -> 3 R beats of SLVERR data 0, last only on beat 3; with r_ready held low 4 cycles the beat is stable.
REQ-035 mtime=64'hFFFF_FFFF_FFFF_FFFF plus a tick -> reads back 0; MTIME_LO write with wstrb=4'b0001 on a tick cycle -> byte 0 takes the written value, upper bytes take the incremented value.
REQ-036 Simultaneous AW and AR in IDLE -> write completes first, read served next; assert arst_ni low during RDATA -> r_valid=0 immediately, no stale beat after reset.

Source files
------------

// File: rtl/p_core_clint.sv
// p_core_clint: AXI4 slave CLINT exposing msip, mtimecmp and a free-running 64-bit mtime.
// Single-outstanding controller; bursts are drained and answered with SLVERR.
package rs_axi_pkg;
   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [5:0]  atop;
   } aw_chan_t;
   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [3:0]  cache;
      logic [2:0]  prot;
   } ar_chan_t;
   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } w_chan_t;
   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;
   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;
   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } rs_m_axi_req_t;
   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } rs_m_axi_resp_t;
endpackage

module p_core_clint import rs_axi_pkg::*; #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int          DATA_W    = 64,
   parameter type         req_t     = rs_m_axi_req_t,
   parameter type         resp_t    = rs_m_axi_resp_t
) (
   input  logic  clk_i,
   input  logic  arst_ni,
   input  req_t  req_i,
   output resp_t resp_o,
   input  logic  rtc_tick_i,
   output logic  time_irq_o,
   output logic  ipi_o
);
   typedef enum logic [2:0] {IDLE, WDATA, WDRAIN, BRESP, RDATA} state_t;
   state_t state, state_n;
   logic live, msip, aw_rdy, ar_rdy, w_rdy, aw_hs, ar_hs, w_hs, we, rhit, whit, unused;
   logic [3:0] id, wstrb;
   logic [31:2] waddr;
   logic [1:0] bresp, rresp;
   logic [7:0] cnt;
   logic [15:0] roff, woff;
   logic [31:0] rword, wword;
   logic [63:0] rdata, mtime, mtimecmp, mtime_n;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   // live holds every ready low until the first edge after reset release
   assign aw_rdy = live && state == IDLE;
   assign ar_rdy = aw_rdy && !req_i.aw_valid;
   assign w_rdy  = state == WDATA || state == WDRAIN;
   assign aw_hs  = aw_rdy && req_i.aw_valid;
   assign ar_hs  = ar_rdy && req_i.ar_valid;
   assign w_hs   = w_rdy && req_i.w_valid;
   assign ipi_o  = msip;
   assign unused = ^req_i;

   assign roff  = {req_i.ar.addr[15:2], 2'b00};
   assign rhit  = req_i.ar.addr[31:16] == BASE_ADDR[31:16];
   assign rword = !rhit ? '0 : roff == 16'h0000 ? {31'b0, msip} : roff == 16'h4000 ? mtimecmp[31:0] :
                  roff == 16'h4004 ? mtimecmp[63:32] : roff == 16'hBFF8 ? mtime[31:0] :
                  roff == 16'hBFFC ? mtime[63:32] : '0;

   assign woff  = {waddr[15:2], 2'b00};
   assign whit  = waddr[31:16] == BASE_ADDR[31:16];
   assign wword = (DATA_W == 64 && waddr[2]) ? req_i.w.data[63:32] : req_i.w.data[31:0];
   assign wstrb = (DATA_W == 64 && waddr[2]) ? req_i.w.strb[7:4] : req_i.w.strb[3:0];
   assign we    = w_hs && state == WDATA && whit;

   // a write landing on a tick cycle overrides only its strobed bytes of the incremented time
   always_comb begin
      mtime_n = mtime + 64'(rtc_tick_i);
      if (we && woff == 16'hBFF8) mtime_n[31:0] = merge(mtime_n[31:0], wword, wstrb);
      if (we && woff == 16'hBFFC) mtime_n[63:32] = merge(mtime_n[63:32], wword, wstrb);
   end

   always_ff @(posedge clk_i or negedge arst_ni)
      if (!arst_ni) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = aw_hs ? (req_i.aw.len == '0 ? WDATA : WDRAIN) : ar_hs ? RDATA : IDLE;
         WDATA:   if (w_hs) state_n = BRESP;
         WDRAIN:  if (w_hs && req_i.w.last) state_n = BRESP;
         BRESP:   if (req_i.b_ready) state_n = IDLE;
         RDATA:   if (req_i.r_ready && cnt == '0) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_ni)
      if (!arst_ni) begin
         live       <= 1'b0;
         id         <= '0;
         waddr      <= '0;
         bresp      <= '0;
         rresp      <= '0;
         cnt        <= '0;
         rdata      <= '0;
         mtime      <= '0;
         mtimecmp   <= '1;
         msip       <= 1'b0;
         time_irq_o <= 1'b0;
      end else begin
         live       <= 1'b1;
         mtime      <= mtime_n;
         time_irq_o <= mtime >= mtimecmp;
         if (we && woff == 16'h0000 && wstrb[0]) msip <= wword[0];
         if (we && woff == 16'h4000) mtimecmp[31:0] <= merge(mtimecmp[31:0], wword, wstrb);
         if (we && woff == 16'h4004) mtimecmp[63:32] <= merge(mtimecmp[63:32], wword, wstrb);
         if (aw_hs) begin
            id    <= req_i.aw.id;
            waddr <= req_i.aw.addr[31:2];
            bresp <= req_i.aw.len == '0 ? 2'b00 : 2'b10;
         end
         if (ar_hs) begin
            id    <= req_i.ar.id;
            cnt   <= req_i.ar.len;
            rresp <= req_i.ar.len == '0 ? 2'b00 : 2'b10;
            rdata <= req_i.ar.len != '0 ? '0 :
                     (DATA_W == 64 && req_i.ar.addr[2]) ? {rword, 32'h0} : {32'h0, rword};
         end
         if (state == RDATA && req_i.r_ready) cnt <= cnt - 8'd1;
      end

   always_comb begin
      resp_o          = '0;
      resp_o.aw_ready = aw_rdy;
      resp_o.ar_ready = ar_rdy;
      resp_o.w_ready  = w_rdy;
      resp_o.b_valid  = state == BRESP;
      resp_o.b.id     = id;
      resp_o.b.resp   = bresp;
      resp_o.r_valid  = state == RDATA;
      resp_o.r.id     = id;
      resp_o.r.data   = rdata;
      resp_o.r.resp   = rresp;
      resp_o.r.last   = cnt == '0;
   end
endmodule

// File: tb/tb_p_core_clint.sv
// tb_p_core_clint: drives AXI transactions and rtc ticks, checking against a register-level model.
module tb_p_core_clint;
   import rs_axi_pkg::*;
   localparam logic [15:0] BASE_HI = 16'h0200;
   localparam logic [31:0] BASE = 32'h0200_0000;
   localparam int LIM = 40;

   logic clk = 1'b0, arst_n = 1'b1, rtc_tick = 1'b0, time_irq, ipi, ipi_at_w;
   rs_m_axi_req_t req;
   rs_m_axi_resp_t resp;
   int checks = 0, failures = 0;
   logic [63:0] m_mtime, m_cmp;
   logic m_msip;

   p_core_clint dut (.clk_i(clk), .arst_ni(arst_n), .req_i(req), .resp_o(resp),
                     .rtc_tick_i(rtc_tick), .time_irq_o(time_irq), .ipi_o(ipi));

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (a[31:16] != BASE_HI) return 32'h0;
      case ({a[15:2], 2'b00})
         16'h0000: return {31'b0, m_msip};
         16'h4000: return m_cmp[31:0];
         16'h4004: return m_cmp[63:32];
         16'hBFF8: return m_mtime[31:0];
         16'hBFFC: return m_mtime[63:32];
         default:  return 32'h0;
      endcase
   endfunction

   function automatic logic [63:0] exp_rd(input logic [31:0] a);
      logic [31:0] w;
      w = m_read(a);
      return a[2] ? {w, 32'h0} : {32'h0, w};
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
      logic [31:0] w;
      logic [3:0] s4;
      w  = a[2] ? d[63:32] : d[31:0];
      s4 = a[2] ? s[7:4] : s[3:0];
      if (a[31:16] == BASE_HI)
         case ({a[15:2], 2'b00})
            16'h0000: if (s4[0]) m_msip = w[0];
            16'h4000: m_cmp[31:0] = mrg(m_cmp[31:0], w, s4);
            16'h4004: m_cmp[63:32] = mrg(m_cmp[63:32], w, s4);
            16'hBFF8: m_mtime[31:0] = mrg(m_mtime[31:0], w, s4);
            16'hBFFC: m_mtime[63:32] = mrg(m_mtime[63:32], w, s4);
            default: ;
         endcase
   endtask

   task automatic m_reset();
      m_mtime = '0;
      m_cmp   = '1;
      m_msip  = 1'b0;
   endtask

   task automatic do_reset();
      req = '0;
      rtc_tick = 1'b0;
      #2 arst_n = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      arst_n = 1'b1;
      cyc();
   endtask

   task automatic tick();
      rtc_tick = 1'b1;
      cyc();
      rtc_tick = 1'b0;
      m_mtime = m_mtime + 64'd1;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input logic [7:0] len, input logic [3:0] id, input logic tk,
                            output logic [1:0] br, output logic [3:0] bid, output int beats);
      int n;
      beats = 0;
      br = 2'bxx;
      bid = 'x;
      req.aw = '0;
      req.aw.addr = a;
      req.aw.len = len;
      req.aw.id = id;
      req.aw.size = 3'd3;
      req.aw.burst = 2'b01;
      req.aw_valid = 1'b1;
      #1;
      n = 0;
      while (!resp.aw_ready && n < LIM) begin cyc(); n++; end
      if (n == LIM) begin failures++; $display("FAIL aw_timeout: aw_ready=0 for %0d cycles, required 1", LIM); end
      cyc();
      req.aw_valid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         req.w.data = d;
         req.w.strb = s;
         req.w.last = b == int'(len);
         req.w_valid = 1'b1;
         #1;
         n = 0;
         while (!resp.w_ready && n < LIM) begin cyc(); n++; end
         if (n == LIM) begin failures++; $display("FAIL w_timeout: w_ready=0 on beat %0d, required 1", b); break; end
         rtc_tick = tk;
         cyc();
         rtc_tick = 1'b0;
         beats++;
      end
      ipi_at_w = ipi;
      req.w_valid = 1'b0;
      req.b_ready = 1'b1;
      #1;
      n = 0;
      while (!resp.b_valid && n < LIM) begin cyc(); n++; end
      if (n == LIM) begin failures++; $display("FAIL b_timeout: b_valid=0 for %0d cycles, required 1", LIM); end
      else begin br = resp.b.resp; bid = resp.b.id; end
      cyc();
      req.b_ready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, input logic [3:0] id, output logic [63:0] d,
                           output logic [1:0] rr, output logic [3:0] rid, output logic last);
      int n;
      d = 'x;
      rr = 2'bxx;
      rid = 'x;
      last = 1'bx;
      req.ar = '0;
      req.ar.addr = a;
      req.ar.id = id;
      req.ar_valid = 1'b1;
      #1;
      n = 0;
      while (!resp.ar_ready && n < LIM) begin cyc(); n++; end
      if (n == LIM) begin failures++; $display("FAIL ar_timeout: ar_ready=0 for %0d cycles, required 1", LIM); end
      cyc();
      req.ar_valid = 1'b0;
      req.r_ready = 1'b1;
      #1;
      n = 0;
      while (!resp.r_valid && n < LIM) begin cyc(); n++; end
      if (n == LIM) begin failures++; $display("FAIL r_timeout: r_valid=0 for %0d cycles, required 1", LIM); end
      else begin d = resp.r.data; rr = resp.r.resp; rid = resp.r.id; last = resp.r.last; end
      cyc();
      req.r_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [63:0] d;
      logic [1:0] rr;
      logic [3:0] rid;
      logic last;
      logic [31:0] regs [5];
      regs = '{BASE + 32'h0000, BASE + 32'h4000, BASE + 32'h4004, BASE + 32'hBFF8, BASE + 32'hBFFC};
      req = '0;
      #3 arst_n = 1'b0;
      m_reset();
      #1;
      checks++;
      if ({resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid, time_irq, ipi} !== 7'b0) begin
         failures++;
         $display("FAIL reset_outputs: got %b, required 0000000",
                  {resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid, time_irq, ipi});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      arst_n = 1'b1;
      #1;
      checks++;
      if ({resp.aw_ready, resp.ar_ready} !== 2'b00) begin
         failures++;
         $display("FAIL ready_after_release: got %b, required 00 before first edge", {resp.aw_ready, resp.ar_ready});
      end
      cyc();
      checks++;
      if ({resp.aw_ready, resp.ar_ready} !== 2'b11) begin
         failures++;
         $display("FAIL ready_first_cycle: got %b, required 11", {resp.aw_ready, resp.ar_ready});
      end
      foreach (regs[i]) begin
         axi_read(regs[i], 4'(i), d, rr, rid, last);
         checks++;
         if ({d, rr, rid, last} !== {exp_rd(regs[i]), 2'b00, 4'(i), 1'b1}) begin
            failures++;
            $display("FAIL reset_read %h: got data=%h resp=%b id=%h last=%b, required data=%h resp=00 id=%h last=1",
                     regs[i], d, rr, rid, last, exp_rd(regs[i]), 4'(i));
         end
      end
   endtask

   task automatic test_msip();
      logic [1:0] br;
      logic [3:0] bid;
      int beats;
      axi_write(BASE, 64'h1, 8'h0F, 8'd0, 4'h5, 1'b0, br, bid, beats);
      m_write(BASE, 64'h1, 8'h0F);
      checks++;
      if ({br, bid, ipi_at_w} !== {2'b00, 4'h5, 1'b1}) begin
         failures++;
         $display("FAIL msip_set: got resp=%b id=%h ipi=%b, required resp=00 id=5 ipi=1", br, bid, ipi_at_w);
      end
      axi_write(BASE, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 8'd0, 4'hA, 1'b0, br, bid, beats);
      m_write(BASE, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
      checks++;
      if ({br, bid, ipi_at_w, ipi} !== {2'b00, 4'hA, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL msip_clear: got resp=%b id=%h ipi_w=%b ipi=%b, required resp=00 id=a ipi 0 0", br, bid, ipi_at_w, ipi);
      end
   endtask

   task automatic test_timer_irq();
      logic [1:0] br;
      logic [3:0] bid;
      int beats;
      do_reset();
      axi_write(BASE + 32'h4004, 64'h0, 8'hF0, 8'd0, 4'h1, 1'b0, br, bid, beats);
      m_write(BASE + 32'h4004, 64'h0, 8'hF0);
      axi_write(BASE + 32'h4000, 64'h5, 8'h0F, 8'd0, 4'h2, 1'b0, br, bid, beats);
      m_write(BASE + 32'h4000, 64'h5, 8'h0F);
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (time_irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_before_cmp tick %0d: got %b, required 0", i, time_irq);
         end
      end
      cyc();
      checks++;
      if (time_irq !== (m_mtime >= m_cmp)) begin
         failures++;
         $display("FAIL irq_rise: got %b, required %b", time_irq, m_mtime >= m_cmp);
      end
      axi_write(BASE + 32'h4004, 64'h1_0000_0000, 8'hF0, 8'd0, 4'h3, 1'b0, br, bid, beats);
      m_write(BASE + 32'h4004, 64'h1_0000_0000, 8'hF0);
      checks++;
      if (time_irq !== (m_mtime >= m_cmp)) begin
         failures++;
         $display("FAIL irq_fall: got %b, required %b", time_irq, m_mtime >= m_cmp);
      end
   endtask

   task automatic test_wdrain();
      logic [1:0] br;
      logic [3:0] bid;
      int beats;
      logic [63:0] d;
      logic [1:0] rr;
      logic [3:0] rid;
      logic last;
      axi_write(BASE + 32'h4000, 64'h0000_0000_0000_0001, 8'hFF, 8'd3, 4'h7, 1'b0, br, bid, beats);
      checks++;
      if ({beats, br, bid} !== {32'd4, 2'b10, 4'h7}) begin
         failures++;
         $display("FAIL wdrain: got beats=%0d resp=%b id=%h, required beats=4 resp=10 id=7", beats, br, bid);
      end
      axi_read(BASE + 32'h4000, 4'h8, d, rr, rid, last);
      checks++;
      if (d !== exp_rd(BASE + 32'h4000)) begin
         failures++;
         $display("FAIL wdrain_unchanged: got %h, required %h", d, exp_rd(BASE + 32'h4000));
      end
   endtask

   task automatic test_rdrain();
      r_chan_t snap;
      int n;
      req.ar = '0;
      req.ar.addr = BASE + 32'hBFF8;
      req.ar.len = 8'd2;
      req.ar.id = 4'h9;
      req.ar_valid = 1'b1;
      #1;
      n = 0;
      while (!resp.ar_ready && n < LIM) begin cyc(); n++; end
      if (n == LIM) begin failures++; $display("FAIL rdrain_ar_timeout: ar_ready=0, required 1"); end
      cyc();
      req.ar_valid = 1'b0;
      req.r_ready = 1'b0;
      snap = resp.r;
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++;
         if ({resp.r_valid, resp.r} !== {1'b1, snap}) begin
            failures++;
            $display("FAIL r_stable cycle %0d: got valid=%b r=%h, required valid=1 r=%h", i, resp.r_valid, resp.r, snap);
         end
      end
      req.r_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         #1;
         checks++;
         if ({resp.r_valid, resp.r} !== {1'b1, 4'h9, 64'h0, 2'b10, b == 2}) begin
            failures++;
            $display("FAIL rdrain_beat %0d: got valid=%b id=%h data=%h resp=%b last=%b, required 1 9 0 10 %b",
                     b, resp.r_valid, resp.r.id, resp.r.data, resp.r.resp, resp.r.last, b == 2);
         end
         cyc();
      end
      checks++;
      if (resp.r_valid !== 1'b0) begin
         failures++;
         $display("FAIL rdrain_extra_beat: got r_valid=%b, required 0", resp.r_valid);
      end
      req.r_ready = 1'b0;
   endtask

   task automatic test_wrap();
      logic [1:0] br, rr;
      logic [3:0] bid, rid;
      logic [63:0] d, wd;
      logic last;
      int beats;
      axi_write(BASE + 32'hBFF8, 64'hFFFF_FFFF, 8'h0F, 8'd0, 4'h1, 1'b0, br, bid, beats);
      m_write(BASE + 32'hBFF8, 64'hFFFF_FFFF, 8'h0F);
      axi_write(BASE + 32'hBFFC, 64'hFFFF_FFFF_0000_0000, 8'hF0, 8'd0, 4'h2, 1'b0, br, bid, beats);
      m_write(BASE + 32'hBFFC, 64'hFFFF_FFFF_0000_0000, 8'hF0);
      tick();
      axi_read(BASE + 32'hBFF8, 4'h3, d, rr, rid, last);
      checks++;
      if (d !== exp_rd(BASE + 32'hBFF8) || m_mtime !== 64'h0) begin
         failures++;
         $display("FAIL wrap_lo: got %h, required %h (model mtime %h)", d, exp_rd(BASE + 32'hBFF8), m_mtime);
      end
      axi_read(BASE + 32'hBFFC, 4'h4, d, rr, rid, last);
      checks++;
      if (d !== exp_rd(BASE + 32'hBFFC)) begin
         failures++;
         $display("FAIL wrap_hi: got %h, required %h", d, exp_rd(BASE + 32'hBFFC));
      end
      axi_write(BASE + 32'hBFF8, 64'hFFFF_FFFF, 8'h0F, 8'd0, 4'h5, 1'b0, br, bid, beats);
      m_write(BASE + 32'hBFF8, 64'hFFFF_FFFF, 8'h0F);
      wd = {$urandom, $urandom};
      wd[7:0] = 8'h5A;
      axi_write(BASE + 32'hBFF8, wd, 8'h01, 8'd0, 4'h6, 1'b1, br, bid, beats);
      m_mtime = m_mtime + 64'd1;
      m_write(BASE + 32'hBFF8, wd, 8'h01);
      axi_read(BASE + 32'hBFF8, 4'h7, d, rr, rid, last);
      checks++;
      if (d !== exp_rd(BASE + 32'hBFF8)) begin
         failures++;
         $display("FAIL tick_write_lo: got %h, required %h", d, exp_rd(BASE + 32'hBFF8));
      end
      axi_read(BASE + 32'hBFFC, 4'h8, d, rr, rid, last);
      checks++;
      if (d !== exp_rd(BASE + 32'hBFFC)) begin
         failures++;
         $display("FAIL tick_write_hi: got %h, required %h", d, exp_rd(BASE + 32'hBFFC));
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] br, rr;
      logic [3:0] bid, rid;
      logic [63:0] d;
      logic last;
      int beats, n;
      req.ar = '0;
      req.ar.addr = BASE;
      req.ar.id = 4'hC;
      req.aw_valid = 1'b1;
      req.ar_valid = 1'b1;
      #1;
      checks++;
      if ({resp.aw_ready, resp.ar_ready} !== 2'b10) begin
         failures++;
         $display("FAIL aw_priority: got aw_ready/ar_ready=%b, required 10", {resp.aw_ready, resp.ar_ready});
      end
      axi_write(BASE, 64'h1, 8'h01, 8'd0, 4'hB, 1'b0, br, bid, beats);
      m_write(BASE, 64'h1, 8'h01);
      n = 0;
      while (!resp.ar_ready && n < LIM) begin cyc(); n++; end
      cyc();
      req.ar_valid = 1'b0;
      req.r_ready = 1'b1;
      #1;
      checks++;
      if ({resp.r_valid, resp.r.id, resp.r.data} !== {1'b1, 4'hC, exp_rd(BASE)}) begin
         failures++;
         $display("FAIL read_after_write: got valid=%b id=%h data=%h, required 1 c %h",
                  resp.r_valid, resp.r.id, resp.r.data, exp_rd(BASE));
      end
      cyc();
      req.r_ready = 1'b0;
      req.ar.addr = BASE + 32'h4004;
      req.ar.id = 4'hD;
      req.ar_valid = 1'b1;
      #1;
      n = 0;
      while (!resp.ar_ready && n < LIM) begin cyc(); n++; end
      cyc();
      req.ar_valid = 1'b0;
      cyc();
      checks++;
      if (resp.r_valid !== 1'b1) begin
         failures++;
         $display("FAIL rdata_before_reset: got r_valid=%b, required 1", resp.r_valid);
      end
      #2 arst_n = 1'b0;
      m_reset();
      #1;
      checks++;
      if ({resp.r_valid, ipi} !== 2'b00) begin
         failures++;
         $display("FAIL async_reset_rdata: got r_valid=%b ipi=%b, required 00", resp.r_valid, ipi);
      end
      @(negedge clk);
      arst_n = 1'b1;
      req.r_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         checks++;
         if (resp.r_valid !== 1'b0) begin
            failures++;
            $display("FAIL stale_beat cycle %0d: got r_valid=%b, required 0", i, resp.r_valid);
         end
      end
      req.r_ready = 1'b0;
      axi_read(BASE + 32'h4004, 4'hE, d, rr, rid, last);
      checks++;
      if ({d, rr, rid} !== {exp_rd(BASE + 32'h4004), 2'b00, 4'hE}) begin
         failures++;
         $display("FAIL read_after_reset: got data=%h resp=%b id=%h, required %h 00 e", d, rr, rid, exp_rd(BASE + 32'h4004));
      end
   endtask

   task automatic test_random();
      logic [15:0] offs [7];
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0] s;
      logic [3:0] id, bid, rid;
      logic [1:0] br, rr;
      logic last;
      int beats;
      offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0008, 16'h8000};
      for (int it = 0; it < 40; it++) begin
         a = (($urandom_range(0, 5) == 0) ? 32'h0201_0000 : BASE) + 32'(offs[$urandom_range(0, 6)]);
         d = {$urandom, $urandom};
         s = 8'($urandom);
         id = 4'($urandom);
         axi_write(a, d, s, 8'd0, id, 1'b0, br, bid, beats);
         m_write(a, d, s);
         checks++;
         if ({br, bid} !== {2'b00, id}) begin
            failures++;
            $display("FAIL rand_b %0d: got resp=%b id=%h, required 00 %h", it, br, bid, id);
         end
         repeat ($urandom_range(0, 3)) tick();
         a = BASE + 32'(offs[$urandom_range(0, 6)]);
         id = 4'($urandom);
         axi_read(a, id, d, rr, rid, last);
         checks++;
         if ({d, rr, rid, last} !== {exp_rd(a), 2'b00, id, 1'b1}) begin
            failures++;
            $display("FAIL rand_r %0d addr %h: got data=%h resp=%b id=%h last=%b, required %h 00 %h 1",
                     it, a, d, rr, rid, last, exp_rd(a), id);
         end
         checks++;
         if ({time_irq, ipi} !== {m_mtime >= m_cmp, m_msip}) begin
            failures++;
            $display("FAIL rand_irq %0d: got irq=%b ipi=%b, required %b %b", it, time_irq, ipi, m_mtime >= m_cmp, m_msip);
         end
      end
   endtask

   initial begin
      req = '0;
      m_reset();
      test_reset();
      test_msip();
      test_timer_irq();
      test_wdrain();
      test_rdrain();
      test_wrap();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
